cc_speed_monitor: RTL and testbench
===================================

Name: cc_speed_monitor

Overview:
- Multi-channel, clocked successor to the single-channel speed comparator.
- Each channel compares a sampled speed word against its own programmable high/low limit pair, with hysteresis and N-sample confirmation (debounce).
- Drives a per-channel active-low alarm, an aggregate alarm and sticky flags.
- Sits between the speed-measurement counters and the motor-control/alarm logic.

Parameters:
- SPEEDMONITOR_DATAWIDTH, 8, width of each speed sample and each limit.
- SPEEDMONITOR_CHANNELS, 4, number of independent channels (1..16).
- SPEEDMONITOR_CONFIRM, 3, consecutive qualifying samples needed to change state (1..15).
- SPEEDMONITOR_CHWIDTH, 2, channel-select width; must equal clog2(CHANNELS), minimum 1.

Ports:
- CC_SPEEDMONITOR_CLOCK_50  in  1  system clock; every register uses the rising edge.
- CC_SPEEDMONITOR_RESET_InLow  in  1  asynchronous, active-low reset.
- CC_SPEEDMONITOR_data_InBUS  in  CHANNELS*DATAWIDTH  speed samples; channel k occupies bits [k*W +: W].
- CC_SPEEDMONITOR_sample_InHigh  in  CHANNELS  per-channel sample-valid strobe.
- CC_SPEEDMONITOR_limitHigh_InBUS  in  DATAWIDTH  alarm-on threshold to load.
- CC_SPEEDMONITOR_limitLow_InBUS  in  DATAWIDTH  alarm-off threshold to load.
- CC_SPEEDMONITOR_limitChannel_InBUS  in  CHWIDTH  target channel of a load.
- CC_SPEEDMONITOR_loadSignal_InLow  in  1  load request; acts on its falling edge only.
- CC_SPEEDMONITOR_loadAck_OutHigh  out  1  one-cycle acknowledge of an accepted load.
- CC_SPEEDMONITOR_clearSticky_InHigh  in  CHANNELS  per-channel sticky clear.
- CC_SPEEDMONITOR_signal_OutLow  out  CHANNELS  per-channel alarm, active low.
- CC_SPEEDMONITOR_anySignal_OutLow  out  1  AND of all signal_OutLow bits (low if any channel is in alarm).
- CC_SPEEDMONITOR_sticky_OutHigh  out  CHANNELS  latched "alarm occurred" flags.

Behaviour:
- Reset (asynchronous, applies immediately, including mid-operation):
  - all FSMs go to BELOW and all counters to 0;
  - limitHigh = limitLow = all ones;
  - signal_OutLow all 1, anySignal_OutLow 1, sticky 0, loadAck 0;
  - the load-edge history register is set to 1.
- Load:
  - loadSignal_InLow is registered once; a falling edge is prev=1 and cur=0.
  - On the edge cycle, if limitChannel < CHANNELS: write both limits to that channel and pulse loadAck high for exactly the next cycle.
  - If limitChannel >= CHANNELS: ignore the load and give no ack.
  - If limitLow > limitHigh: store limitLow = limitHigh (no hysteresis).
  - Holding loadSignal low does not reload.
  - New limits take effect for samples in the cycle after the write. FSM state and counter are not disturbed.
- Per-channel FSM: 2-bit state plus a CONFIRM-wide counter. Only cycles with sample_InHigh[k]=1 are evaluated; other cycles hold everything.
  - BELOW, sample >= high: go to ALARM if CONFIRM=1, else go to ARM with cnt=1.
  - ARM, sample >= high: go to ALARM when cnt+1 = CONFIRM, else cnt++.
  - ARM, sample < high: return to BELOW with cnt=0.
  - ALARM, sample < low: go to BELOW if CONFIRM=1, else go to DISARM with cnt=1.
  - DISARM, sample < low: go to BELOW when cnt+1 = CONFIRM, else cnt++.
  - DISARM, sample >= low: return to ALARM with cnt=0.
- Comparisons are unsigned, full width, inclusive at the high limit (>=) and strict at the low limit (<).
- Outputs are registered:
  - signal_OutLow[k] = 0 in ALARM and DISARM, 1 in BELOW and ARM.
  - Latency: the output changes on the clock edge that registers the CONFIRM-th qualifying sample (visible one cycle after that sample is presented).
  - anySignal_OutLow is combinational from the registered signal_OutLow bits.
- Sticky:
  - sticky[k] sets on any transition into ALARM from ARM or BELOW.
  - clearSticky[k] clears it.
  - If set and clear occur in the same cycle, set wins.
- A load to channel k in the same cycle as a sample on channel k: the sample is compared against the old limits.

Decomposition:
- Shared package holds:
  - state localparams ST_BELOW=0, ST_ARM=1, ST_ALARM=2, ST_DISARM=3;
  - a clog2 constant function;
  - the reset-limit constant (all ones).
- One sub-module, cc_speed_channel: limits registers, FSM, counter, sticky for one channel. It is instantiated CHANNELS times in a generate loop.
- The top level holds load-edge detection, channel decode, loadAck and anySignal.

Test Plan:
- Reset and load: reset, then load ch2 with high=100, low=80 via a falling edge of loadSignal. Expect loadAck high exactly 1 cycle, then all outputs 1. Hold loadSignal low for 5 cycles and expect no second ack.
- Confirm debounce (W=8, CONFIRM=3): ch2 samples 100, 100, 99, 100, 100, 100. Expect signal_OutLow[2] low only after the last sample, sticky[2]=1, anySignal_OutLow=0.
- Hysteresis on ch2: samples 90 ×5 keep the alarm; then 79, 79, 85, 79, 79, 79. Expect release only after the final three 79s. Samples with sample_InHigh=0 between them must not advance or clear the count.
- Edge cases: load with limitChannel=3 while CHANNELS=3 gives no ack and no change. Load with low=120, high=100 stores low=100. Sticky set and clear in the same cycle leaves sticky=1.
- Channel independence: drive all 4 channels with different limits and interleaved valids. Expect only channels with 3 qualifying samples to alarm, and anySignal to track the AND of the per-channel bits.
- Reset mid-operation: assert RESET_InLow low asynchronously while ch0 is in DISARM with cnt=2. Expect outputs 1, sticky 0 and limits all ones immediately, before the next clock edge.

Source files
------------

// File: rtl/cc_speed_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cc_speed_monitor_pkg
// Brief   : Shared state encoding, sizing helper and reset constants for the
//           multi-channel speed monitor.
// Revision: 1.0
// ============================================================================
package cc_speed_monitor_pkg;

    localparam logic [1:0] ST_BELOW  = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_ALARM  = 2'd2;
    localparam logic [1:0] ST_DISARM = 2'd3;

    typedef enum logic [1:0] {
        S_BELOW  = ST_BELOW,
        S_ARM    = ST_ARM,
        S_ALARM  = ST_ALARM,
        S_DISARM = ST_DISARM
    } state_t;

    // Debounce counter holds up to CONFIRM-1, and CONFIRM never exceeds 15.
    localparam int c_CNT_WIDTH = 4;

    // Limits reset to all ones so an unprogrammed channel only alarms at full scale.
    localparam logic [63:0] c_LIMIT_RESET = '1;

    // Ceiling log2 with a floor of 1, so a single channel still has a select bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_speed_monitor_if.sv
`default_nettype none
// ============================================================================
// Module  : cc_speed_monitor_if
// Brief   : Sample, limit-load and alarm bundle between the speed counters,
//           the monitor and the motor-control/alarm logic.
// Revision: 1.0
// ============================================================================
interface cc_speed_monitor_if
    import cc_speed_monitor_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int CHANNELS  = 4,
    parameter int CHWIDTH   = clog2(CHANNELS)
);

    logic [CHANNELS*DATAWIDTH-1:0] CC_SPEEDMONITOR_data_InBUS;
    logic [CHANNELS-1:0]           CC_SPEEDMONITOR_sample_InHigh;
    logic [DATAWIDTH-1:0]          CC_SPEEDMONITOR_limitHigh_InBUS;
    logic [DATAWIDTH-1:0]          CC_SPEEDMONITOR_limitLow_InBUS;
    logic [CHWIDTH-1:0]            CC_SPEEDMONITOR_limitChannel_InBUS;
    logic                          CC_SPEEDMONITOR_loadSignal_InLow;
    logic                          CC_SPEEDMONITOR_loadAck_OutHigh;
    logic [CHANNELS-1:0]           CC_SPEEDMONITOR_clearSticky_InHigh;
    logic [CHANNELS-1:0]           CC_SPEEDMONITOR_signal_OutLow;
    logic                          CC_SPEEDMONITOR_anySignal_OutLow;
    logic [CHANNELS-1:0]           CC_SPEEDMONITOR_sticky_OutHigh;

    modport master (
        output CC_SPEEDMONITOR_data_InBUS,
        output CC_SPEEDMONITOR_sample_InHigh,
        output CC_SPEEDMONITOR_limitHigh_InBUS,
        output CC_SPEEDMONITOR_limitLow_InBUS,
        output CC_SPEEDMONITOR_limitChannel_InBUS,
        output CC_SPEEDMONITOR_loadSignal_InLow,
        input  CC_SPEEDMONITOR_loadAck_OutHigh,
        output CC_SPEEDMONITOR_clearSticky_InHigh,
        input  CC_SPEEDMONITOR_signal_OutLow,
        input  CC_SPEEDMONITOR_anySignal_OutLow,
        input  CC_SPEEDMONITOR_sticky_OutHigh
    );

    modport slave (
        input  CC_SPEEDMONITOR_data_InBUS,
        input  CC_SPEEDMONITOR_sample_InHigh,
        input  CC_SPEEDMONITOR_limitHigh_InBUS,
        input  CC_SPEEDMONITOR_limitLow_InBUS,
        input  CC_SPEEDMONITOR_limitChannel_InBUS,
        input  CC_SPEEDMONITOR_loadSignal_InLow,
        output CC_SPEEDMONITOR_loadAck_OutHigh,
        input  CC_SPEEDMONITOR_clearSticky_InHigh,
        output CC_SPEEDMONITOR_signal_OutLow,
        output CC_SPEEDMONITOR_anySignal_OutLow,
        output CC_SPEEDMONITOR_sticky_OutHigh
    );

endinterface
`default_nettype wire

// File: rtl/cc_speed_channel.sv
`default_nettype none
// ============================================================================
// Module  : cc_speed_channel
// Brief   : One monitor channel: limit pair, debounced hysteresis FSM,
//           registered active-low alarm and sticky flag.
// Revision: 1.0
// ============================================================================
module cc_speed_channel
    import cc_speed_monitor_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int CONFIRM   = 3
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic [DATAWIDTH-1:0] i_sample,
    input  wire logic                 i_sampleValid,
    input  wire logic                 i_limitWrite,
    input  wire logic [DATAWIDTH-1:0] i_limitHigh,
    input  wire logic [DATAWIDTH-1:0] i_limitLow,
    input  wire logic                 i_clearSticky,
    output logic                      o_signal,
    output logic                      o_sticky
);

    localparam logic [c_CNT_WIDTH-1:0] c_LAST = c_CNT_WIDTH'(CONFIRM - 1);

    state_t                   r_state;
    state_t                   w_stateNext;
    logic [c_CNT_WIDTH-1:0]   r_cnt;
    logic [c_CNT_WIDTH-1:0]   w_cntNext;
    logic [DATAWIDTH-1:0]     r_limitHigh;
    logic [DATAWIDTH-1:0]     r_limitLow;
    logic                     r_signal;
    logic                     r_sticky;
    logic                     w_atHigh;
    logic                     w_belowLow;
    logic                     w_enterAlarm;

    assign w_atHigh   = (i_sample >= r_limitHigh);
    assign w_belowLow = (i_sample <  r_limitLow);

    // A low limit above the high limit collapses to the high limit: no hysteresis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_limitHigh <= c_LIMIT_RESET[DATAWIDTH-1:0];
            r_limitLow  <= c_LIMIT_RESET[DATAWIDTH-1:0];
        end else if (i_limitWrite) begin
            r_limitHigh <= i_limitHigh;
            r_limitLow  <= (i_limitLow > i_limitHigh) ? i_limitHigh : i_limitLow;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_enterAlarm = 1'b0;
        if (i_sampleValid) begin
            case (r_state)
                S_BELOW: begin
                    if (w_atHigh) begin
                        if (CONFIRM == 1) begin
                            w_stateNext  = S_ALARM;
                            w_enterAlarm = 1'b1;
                        end else begin
                            w_stateNext = S_ARM;
                            w_cntNext   = c_CNT_WIDTH'(1);
                        end
                    end
                end
                S_ARM: begin
                    if (!w_atHigh) begin
                        w_stateNext = S_BELOW;
                        w_cntNext   = '0;
                    end else if (r_cnt == c_LAST) begin
                        w_stateNext  = S_ALARM;
                        w_cntNext    = '0;
                        w_enterAlarm = 1'b1;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                S_ALARM: begin
                    if (w_belowLow) begin
                        if (CONFIRM == 1) begin
                            w_stateNext = S_BELOW;
                        end else begin
                            w_stateNext = S_DISARM;
                            w_cntNext   = c_CNT_WIDTH'(1);
                        end
                    end
                end
                S_DISARM: begin
                    if (!w_belowLow) begin
                        w_stateNext = S_ALARM;
                        w_cntNext   = '0;
                    end else if (r_cnt == c_LAST) begin
                        w_stateNext = S_BELOW;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Alarm output follows the next state so it flips on the confirming edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_BELOW;
            r_cnt    <= '0;
            r_signal <= 1'b1;
            r_sticky <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_signal <= !((w_stateNext == S_ALARM) || (w_stateNext == S_DISARM));
            if (w_enterAlarm) begin
                r_sticky <= 1'b1;
            end else if (i_clearSticky) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign o_signal = r_signal;
    assign o_sticky = r_sticky;

endmodule
`default_nettype wire

// File: rtl/cc_speed_monitor.sv
`default_nettype none
// ============================================================================
// Module  : cc_speed_monitor
// Brief   : Multi-channel speed limit monitor: load-edge detection, channel
//           decode, load acknowledge and aggregate alarm around N channels.
// Revision: 1.0
// ============================================================================
module cc_speed_monitor
    import cc_speed_monitor_pkg::*;
#(
    parameter int SPEEDMONITOR_DATAWIDTH = 8,
    parameter int SPEEDMONITOR_CHANNELS  = 4,
    parameter int SPEEDMONITOR_CONFIRM   = 3,
    parameter int SPEEDMONITOR_CHWIDTH   = clog2(SPEEDMONITOR_CHANNELS)
) (
    input  wire logic         CC_SPEEDMONITOR_CLOCK_50,
    input  wire logic         CC_SPEEDMONITOR_RESET_InLow,
    cc_speed_monitor_if.slave speedBus
);

    localparam int W = SPEEDMONITOR_DATAWIDTH;
    localparam logic [SPEEDMONITOR_CHWIDTH:0] c_CHANNELS =
        (SPEEDMONITOR_CHWIDTH + 1)'(SPEEDMONITOR_CHANNELS);

    logic                             r_loadPrev;
    logic                             r_loadAck;
    logic                             w_loadEdge;
    logic                             w_channelInRange;
    logic                             w_loadAccept;
    logic [SPEEDMONITOR_CHANNELS-1:0] w_limitWrite;
    logic [SPEEDMONITOR_CHANNELS-1:0] w_signal;
    logic [SPEEDMONITOR_CHANNELS-1:0] w_sticky;

    // History resets high so a load held low through reset still loads once.
    assign w_loadEdge       = r_loadPrev && !speedBus.CC_SPEEDMONITOR_loadSignal_InLow;
    assign w_channelInRange = ({1'b0, speedBus.CC_SPEEDMONITOR_limitChannel_InBUS} < c_CHANNELS);
    assign w_loadAccept     = w_loadEdge && w_channelInRange;

    always_ff @(posedge CC_SPEEDMONITOR_CLOCK_50 or negedge CC_SPEEDMONITOR_RESET_InLow) begin
        if (!CC_SPEEDMONITOR_RESET_InLow) begin
            r_loadPrev <= 1'b1;
            r_loadAck  <= 1'b0;
        end else begin
            r_loadPrev <= speedBus.CC_SPEEDMONITOR_loadSignal_InLow;
            r_loadAck  <= w_loadAccept;
        end
    end

    generate
        for (genvar k = 0; k < SPEEDMONITOR_CHANNELS; k++) begin : g_channel
            assign w_limitWrite[k] = w_loadAccept &&
                (speedBus.CC_SPEEDMONITOR_limitChannel_InBUS == SPEEDMONITOR_CHWIDTH'(k));

            cc_speed_channel #(
                .DATAWIDTH (W),
                .CONFIRM   (SPEEDMONITOR_CONFIRM)
            ) u_channel (
                .clk           (CC_SPEEDMONITOR_CLOCK_50),
                .rst_n         (CC_SPEEDMONITOR_RESET_InLow),
                .i_sample      (speedBus.CC_SPEEDMONITOR_data_InBUS[k*W +: W]),
                .i_sampleValid (speedBus.CC_SPEEDMONITOR_sample_InHigh[k]),
                .i_limitWrite  (w_limitWrite[k]),
                .i_limitHigh   (speedBus.CC_SPEEDMONITOR_limitHigh_InBUS),
                .i_limitLow    (speedBus.CC_SPEEDMONITOR_limitLow_InBUS),
                .i_clearSticky (speedBus.CC_SPEEDMONITOR_clearSticky_InHigh[k]),
                .o_signal      (w_signal[k]),
                .o_sticky      (w_sticky[k])
            );
        end
    endgenerate

    assign speedBus.CC_SPEEDMONITOR_loadAck_OutHigh  = r_loadAck;
    assign speedBus.CC_SPEEDMONITOR_signal_OutLow    = w_signal;
    assign speedBus.CC_SPEEDMONITOR_anySignal_OutLow = &w_signal;
    assign speedBus.CC_SPEEDMONITOR_sticky_OutHigh   = w_sticky;

endmodule
`default_nettype wire

// File: tb/tb_cc_speed_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_cc_speed_monitor
// Brief   : Self-checking bench for cc_speed_monitor against a debounce model.
// Revision: 1.0
// ============================================================================
module tb_cc_speed_monitor;

    localparam int W = 8;
    localparam int N = 4;
    localparam int C = 3;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    cc_speed_monitor_if #(.DATAWIDTH(W), .CHANNELS(N), .CHWIDTH(2)) busA ();
    cc_speed_monitor_if #(.DATAWIDTH(W), .CHANNELS(3), .CHWIDTH(2)) busB ();

    cc_speed_monitor #(
        .SPEEDMONITOR_DATAWIDTH(W), .SPEEDMONITOR_CHANNELS(N),
        .SPEEDMONITOR_CONFIRM(C), .SPEEDMONITOR_CHWIDTH(2)
    ) dutA (
        .CC_SPEEDMONITOR_CLOCK_50    (clk),
        .CC_SPEEDMONITOR_RESET_InLow (rstN),
        .speedBus                    (busA.slave)
    );

    cc_speed_monitor #(
        .SPEEDMONITOR_DATAWIDTH(W), .SPEEDMONITOR_CHANNELS(3),
        .SPEEDMONITOR_CONFIRM(C), .SPEEDMONITOR_CHWIDTH(2)
    ) dutB (
        .CC_SPEEDMONITOR_CLOCK_50    (clk),
        .CC_SPEEDMONITOR_RESET_InLow (rstN),
        .speedBus                    (busB.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: alarm flag plus length of the current qualifying run.
    int         mHi [N];
    int         mLo [N];
    int         mRun[N];
    bit         mAlarm[N];
    bit [N-1:0] mSticky;
    bit         mAck;
    bit         mPrevLoad;

    logic [N*W-1:0] vData;
    logic [N-1:0]   vValid;
    logic [N-1:0]   vClr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < N; k++) begin
            mHi[k] = 255; mLo[k] = 255; mRun[k] = 0; mAlarm[k] = 0;
        end
        mSticky = '0; mAck = 0; mPrevLoad = 1;
    endtask

    function automatic logic [N*W-1:0] one(input int ch, input logic [W-1:0] v);
        logic [N*W-1:0] r;
        r = '0;
        r[ch*W +: W] = v;
        return r;
    endfunction

    task automatic checkAll(input string tag);
        logic [N-1:0] expSig;
        for (int k = 0; k < N; k++) expSig[k] = !mAlarm[k];
        check({tag, ".signal"}, 32'(busA.CC_SPEEDMONITOR_signal_OutLow), 32'(expSig));
        check({tag, ".any"},    32'(busA.CC_SPEEDMONITOR_anySignal_OutLow), 32'(&expSig));
        check({tag, ".sticky"}, 32'(busA.CC_SPEEDMONITOR_sticky_OutHigh), 32'(mSticky));
        check({tag, ".ack"},    32'(busA.CC_SPEEDMONITOR_loadAck_OutHigh), 32'(mAck));
    endtask

    // One clock of stimulus on DUT A, with the model advanced over the same edge.
    task automatic step(input string tag, input logic [N*W-1:0] data, input logic [N-1:0] valid,
                        input logic [N-1:0] clr, input logic load, input int ch,
                        input int hi, input int lo);
        bit         accept;
        bit [N-1:0] setNow;
        int         s;
        busA.CC_SPEEDMONITOR_data_InBUS         = data;
        busA.CC_SPEEDMONITOR_sample_InHigh      = valid;
        busA.CC_SPEEDMONITOR_clearSticky_InHigh = clr;
        busA.CC_SPEEDMONITOR_loadSignal_InLow   = load;
        busA.CC_SPEEDMONITOR_limitChannel_InBUS = 2'(ch);
        busA.CC_SPEEDMONITOR_limitHigh_InBUS    = 8'(hi);
        busA.CC_SPEEDMONITOR_limitLow_InBUS     = 8'(lo);
        accept = mPrevLoad && !load && (ch < N);
        setNow = '0;
        for (int k = 0; k < N; k++) begin
            if (valid[k]) begin
                s = int'(data[k*W +: W]);
                if (!mAlarm[k]) begin
                    if (s >= mHi[k]) begin
                        mRun[k]++;
                        if (mRun[k] == C) begin
                            mAlarm[k] = 1; mRun[k] = 0; setNow[k] = 1;
                        end
                    end else mRun[k] = 0;
                end else begin
                    if (s < mLo[k]) begin
                        mRun[k]++;
                        if (mRun[k] == C) begin
                            mAlarm[k] = 0; mRun[k] = 0;
                        end
                    end else mRun[k] = 0;
                end
            end
        end
        mSticky = (mSticky & ~clr) | setNow;
        if (accept) begin
            mHi[ch] = hi;
            mLo[ch] = (lo > hi) ? hi : lo;
        end
        mAck = accept;
        mPrevLoad = load;
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", '0, '0, '0, 1'b1, 0, 0, 0);
    endtask

    initial begin
        busA.CC_SPEEDMONITOR_data_InBUS = '0;
        busA.CC_SPEEDMONITOR_sample_InHigh = '0;
        busA.CC_SPEEDMONITOR_clearSticky_InHigh = '0;
        busA.CC_SPEEDMONITOR_loadSignal_InLow = 1'b1;
        busA.CC_SPEEDMONITOR_limitChannel_InBUS = '0;
        busA.CC_SPEEDMONITOR_limitHigh_InBUS = '0;
        busA.CC_SPEEDMONITOR_limitLow_InBUS = '0;
        busB.CC_SPEEDMONITOR_data_InBUS = '0;
        busB.CC_SPEEDMONITOR_sample_InHigh = '0;
        busB.CC_SPEEDMONITOR_clearSticky_InHigh = '0;
        busB.CC_SPEEDMONITOR_loadSignal_InLow = 1'b1;
        busB.CC_SPEEDMONITOR_limitChannel_InBUS = '0;
        busB.CC_SPEEDMONITOR_limitHigh_InBUS = '0;
        busB.CC_SPEEDMONITOR_limitLow_InBUS = '0;
        rstN = 1'b1;
        modelReset();
        #2 rstN = 1'b0;
        #1;
        checkAll("reset");
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        // Three-channel instance: an out-of-range select must neither ack nor write.
        busB.CC_SPEEDMONITOR_limitChannel_InBUS = 2'd3;
        busB.CC_SPEEDMONITOR_limitHigh_InBUS = 8'd10;
        busB.CC_SPEEDMONITOR_limitLow_InBUS = 8'd5;
        busB.CC_SPEEDMONITOR_loadSignal_InLow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("B.oorAck", 32'(busB.CC_SPEEDMONITOR_loadAck_OutHigh), 32'd0);
        end
        busB.CC_SPEEDMONITOR_loadSignal_InLow = 1'b1;
        busB.CC_SPEEDMONITOR_data_InBUS = {3{8'd20}};
        busB.CC_SPEEDMONITOR_sample_InHigh = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check("B.oorSignal", 32'(busB.CC_SPEEDMONITOR_signal_OutLow), 32'h7);
        busB.CC_SPEEDMONITOR_sample_InHigh = 3'b000;
        busB.CC_SPEEDMONITOR_limitChannel_InBUS = 2'd2;
        busB.CC_SPEEDMONITOR_loadSignal_InLow = 1'b0;
        @(posedge clk); #1;
        check("B.ack", 32'(busB.CC_SPEEDMONITOR_loadAck_OutHigh), 32'd1);
        @(posedge clk); #1;
        check("B.ackOnce", 32'(busB.CC_SPEEDMONITOR_loadAck_OutHigh), 32'd0);
        busB.CC_SPEEDMONITOR_loadSignal_InLow = 1'b1;
        busB.CC_SPEEDMONITOR_sample_InHigh = 3'b100;
        repeat (3) @(posedge clk);
        #1;
        check("B.ch2Signal", 32'(busB.CC_SPEEDMONITOR_signal_OutLow), 32'h3);
        check("B.any", 32'(busB.CC_SPEEDMONITOR_anySignal_OutLow), 32'd0);
        busB.CC_SPEEDMONITOR_sample_InHigh = 3'b000;

        // Load ch2 high=100 low=80, then hold the request low.
        step("load2", '0, '0, '0, 1'b0, 2, 100, 80);
        check("load2.ack", 32'(busA.CC_SPEEDMONITOR_loadAck_OutHigh), 32'd1);
        for (int i = 0; i < 5; i++) step("hold", '0, '0, '0, 1'b0, 2, 100, 80);
        check("hold.ack", 32'(busA.CC_SPEEDMONITOR_loadAck_OutHigh), 32'd0);
        idle(1);

        // Debounce: a 99 breaks the run.
        step("deb", one(2, 100), 4'b0100, '0, 1'b1, 0, 0, 0);
        step("deb", one(2, 100), 4'b0100, '0, 1'b1, 0, 0, 0);
        step("deb", one(2,  99), 4'b0100, '0, 1'b1, 0, 0, 0);
        step("deb", one(2, 100), 4'b0100, '0, 1'b1, 0, 0, 0);
        step("deb", one(2, 100), 4'b0100, '0, 1'b1, 0, 0, 0);
        check("deb.notYet", 32'(busA.CC_SPEEDMONITOR_signal_OutLow[2]), 32'd1);
        step("deb", one(2, 100), 4'b0100, '0, 1'b1, 0, 0, 0);
        check("deb.alarm", 32'(busA.CC_SPEEDMONITOR_signal_OutLow[2]), 32'd0);
        check("deb.sticky", 32'(busA.CC_SPEEDMONITOR_sticky_OutHigh[2]), 32'd1);
        check("deb.any", 32'(busA.CC_SPEEDMONITOR_anySignal_OutLow), 32'd0);

        // Hysteresis with invalid cycles interleaved.
        for (int i = 0; i < 5; i++) step("hys90", one(2, 90), 4'b0100, '0, 1'b1, 0, 0, 0);
        step("hys", one(2, 79), 4'b0100, '0, 1'b1, 0, 0, 0);
        step("hys", one(2, 79), 4'b0100, '0, 1'b1, 0, 0, 0);
        step("hys", one(2,  0), 4'b0000, '0, 1'b1, 0, 0, 0);
        step("hys", one(2, 85), 4'b0100, '0, 1'b1, 0, 0, 0);
        step("hys", one(2, 79), 4'b0100, '0, 1'b1, 0, 0, 0);
        step("hys", one(2,  0), 4'b0000, '0, 1'b1, 0, 0, 0);
        step("hys", one(2, 79), 4'b0100, '0, 1'b1, 0, 0, 0);
        step("hys", one(2,  0), 4'b0000, '0, 1'b1, 0, 0, 0);
        check("hys.hold", 32'(busA.CC_SPEEDMONITOR_signal_OutLow[2]), 32'd0);
        step("hys", one(2, 79), 4'b0100, '0, 1'b1, 0, 0, 0);
        check("hys.release", 32'(busA.CC_SPEEDMONITOR_signal_OutLow[2]), 32'd1);
        step("clr2", '0, '0, 4'b0100, 1'b1, 0, 0, 0);

        // Inverted limits collapse; set and clear together keep sticky.
        step("load1", '0, '0, '0, 1'b0, 1, 100, 120);
        idle(1);
        step("inv", one(1, 100), 4'b0010, '0, 1'b1, 0, 0, 0);
        step("inv", one(1, 100), 4'b0010, '0, 1'b1, 0, 0, 0);
        step("inv", one(1, 100), 4'b0010, 4'b0010, 1'b1, 0, 0, 0);
        check("setWins", 32'(busA.CC_SPEEDMONITOR_sticky_OutHigh[1]), 32'd1);
        for (int i = 0; i < 3; i++) step("inv", one(1, 100), 4'b0010, '0, 1'b1, 0, 0, 0);
        check("inv.hold", 32'(busA.CC_SPEEDMONITOR_signal_OutLow[1]), 32'd0);
        for (int i = 0; i < 3; i++) step("inv", one(1, 99), 4'b0010, '0, 1'b1, 0, 0, 0);
        check("inv.release", 32'(busA.CC_SPEEDMONITOR_signal_OutLow[1]), 32'd1);

        // Randomised multi-channel traffic around each channel's active limit.
        for (int k = 0; k < N; k++) begin
            int hi;
            hi = int'($urandom_range(60, 200));
            step("rload", '0, '0, '0, 1'b0, k, hi, int'($urandom_range(hi - 30, hi + 10)));
            idle(1);
        end
        for (int t = 0; t < 400; t++) begin
            bit ld;
            int hi;
            for (int k = 0; k < N; k++) begin
                int centre, v;
                centre = mAlarm[k] ? mLo[k] : mHi[k];
                v = centre - 3 + int'($urandom_range(0, 5));
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                vData[k*W +: W] = 8'(v);
            end
            vValid = 4'($urandom);
            vClr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            ld = ($urandom_range(0, 19) != 0);
            hi = int'($urandom_range(40, 220));
            step("rand", vData, vValid, vClr, ld, int'($urandom_range(0, 3)), hi,
                 int'($urandom_range(hi - 30, hi + 10)));
        end
        idle(1);

        // Asynchronous reset while ch0 sits in DISARM with two low samples counted.
        step("pre", '0, '0, 4'b1111, 1'b0, 0, 50, 40);
        idle(1);
        for (int i = 0; i < 3; i++) step("pre", one(0, 60), 4'b0001, '0, 1'b1, 0, 0, 0);
        step("pre", one(0, 30), 4'b0001, '0, 1'b1, 0, 0, 0);
        step("pre", one(0, 30), 4'b0001, '0, 1'b1, 0, 0, 0);
        check("pre.disarm", 32'(busA.CC_SPEEDMONITOR_signal_OutLow[0]), 32'd0);
        #2 rstN = 1'b0;
        #1;
        check("async.signal", 32'(busA.CC_SPEEDMONITOR_signal_OutLow), 32'hF);
        check("async.any", 32'(busA.CC_SPEEDMONITOR_anySignal_OutLow), 32'd1);
        check("async.sticky", 32'(busA.CC_SPEEDMONITOR_sticky_OutHigh), 32'd0);
        check("async.ack", 32'(busA.CC_SPEEDMONITOR_loadAck_OutHigh), 32'd0);
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) step("rstLim", one(0, 254), 4'b0001, '0, 1'b1, 0, 0, 0);
        check("rstLim.254", 32'(busA.CC_SPEEDMONITOR_signal_OutLow[0]), 32'd1);
        for (int i = 0; i < 3; i++) step("rstLim", one(0, 255), 4'b0001, '0, 1'b1, 0, 0, 0);
        check("rstLim.255", 32'(busA.CC_SPEEDMONITOR_signal_OutLow[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
